// File: rtl/bmem_arbiter.sv
// ---------------------------------------------------------------------------
// bmem_arbiter
//   Shares one burst-memory port between the instruction cache and the data
//   cache. Each cache issues whole-line read or write requests. The arbiter
//   picks one requester at a time (round-robin on ties). It splits a write
//   line into NUM_BEATS bursts and packs NUM_BEATS read beats back into a
//   line. It then pulses a one-cycle resp to the cache that owns the request.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   i_* / d_*             icache / dcache line request interface
//                         (addr, read, write, wdata in; rdata, resp out)
//   bmem_address          line-aligned burst address
//   bmem_read/bmem_write  burst strobes, held for the whole burst
//   bmem_wdata            current write beat
//   bmem_rdata, bmem_resp read beat and per-beat handshake from memory
// ---------------------------------------------------------------------------
module bmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int BEAT_W    = 64,
  parameter int NUM_BEATS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_W-1:0]           i_addr,
  input  logic                        i_read,
  input  logic                        i_write,
  input  logic [BEAT_W*NUM_BEATS-1:0] i_wdata,
  output logic [BEAT_W*NUM_BEATS-1:0] i_rdata,
  output logic                        i_resp,
  input  logic [ADDR_W-1:0]           d_addr,
  input  logic                        d_read,
  input  logic                        d_write,
  input  logic [BEAT_W*NUM_BEATS-1:0] d_wdata,
  output logic [BEAT_W*NUM_BEATS-1:0] d_rdata,
  output logic                        d_resp,
  output logic [ADDR_W-1:0]           bmem_address,
  output logic                        bmem_read,
  output logic                        bmem_write,
  output logic [BEAT_W-1:0]           bmem_wdata,
  input  logic [BEAT_W-1:0]           bmem_rdata,
  input  logic                        bmem_resp
);

  localparam int LINE_W = BEAT_W * NUM_BEATS;
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int CNT_W  = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;
  typedef enum logic [1:0] {REQ_NONE, REQ_I, REQ_D} req_t;

  state_t             state, state_nxt;
  req_t               grant, last_grant;
  logic [CNT_W-1:0]   beat_cnt;
  logic [ADDR_W-1:0]  lat_addr;
  logic [LINE_W-1:0]  lat_line;
  logic [LINE_W-1:0]  buffer;
  logic [LINE_W-1:0]  line_asm;

  logic i_act, d_act, any_act, pick_d, pick_write;
  logic in_burst, beat_fire, last_beat;

  // The byte offset inside a line is never driven to memory.
  logic unused_offset;
  assign unused_offset = ^{i_addr[OFF_W-1:0], d_addr[OFF_W-1:0]};

  assign i_act   = i_read | i_write;
  assign d_act   = d_read | d_write;
  assign any_act = i_act | d_act;
  // On a tie the dcache wins unless it was the most recent owner.
  assign pick_d     = d_act & (~i_act | (last_grant == REQ_I));
  // Write has precedence when a cache raises both strobes.
  assign pick_write = pick_d ? d_write : i_write;

  assign in_burst  = (state == RD_BURST) || (state == WR_BURST);
  assign beat_fire = in_burst & bmem_resp;
  assign last_beat = beat_fire && (beat_cnt == CNT_W'(NUM_BEATS - 1));

  // Read line with the current beat merged in. The final beat goes straight
  // into the cache-facing register, so rdata is valid in the DONE cycle.
  always_comb begin
    line_asm = buffer;
    line_asm[int'(beat_cnt)*BEAT_W +: BEAT_W] = bmem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every variable written in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (any_act)   state_nxt = pick_write ? WR_BURST : RD_BURST;
      RD_BURST: if (last_beat) state_nxt = DONE;
      WR_BURST: if (last_beat) state_nxt = DONE;
      DONE:                    state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Then every
  // register samples pre-edge values and simulation matches the flops.
  // NOTE: the wide line registers are plain flops, not RAM. They are reset
  // because a cleared line buffer and zero outputs after reset are part of
  // the interface contract.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant      <= REQ_NONE;
      last_grant <= REQ_I;
      beat_cnt   <= '0;
      lat_addr   <= '0;
      lat_line   <= '0;
      buffer     <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      if (state == IDLE && any_act) begin
        grant      <= pick_d ? REQ_D : REQ_I;
        last_grant <= pick_d ? REQ_D : REQ_I;
        lat_addr   <= pick_d ? d_addr  : i_addr;
        lat_line   <= pick_d ? d_wdata : i_wdata;
      end
      if (state == DONE) grant <= REQ_NONE;
      // Stall cycles (bmem_resp low) leave the counter and buffer untouched.
      if (beat_fire) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
        if (state == RD_BURST) begin
          buffer <= line_asm;
          if (last_beat) begin
            if (grant == REQ_D) d_rdata <= line_asm;
            else                i_rdata <= line_asm;
          end
        end
      end
    end
  end

  assign bmem_read    = (state == RD_BURST);
  assign bmem_write   = (state == WR_BURST);
  assign bmem_address = {lat_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign bmem_wdata   = lat_line[int'(beat_cnt)*BEAT_W +: BEAT_W];
  assign i_resp       = (state == DONE) && (grant == REQ_I);
  assign d_resp       = (state == DONE) && (grant == REQ_D);

endmodule

// File: tb/tb_bmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bmem_arbiter
//   Self-checking bench for bmem_arbiter. A behavioural burst memory holds
//   whole lines in an associative array. It serves beats with optional
//   stalls. Each test task compares the DUT against the line-level
//   expectations: data integrity, round-robin order and latency.
// ---------------------------------------------------------------------------
module tb_bmem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  i_addr, d_addr;
  logic         i_read, i_write, d_read, d_write;
  logic [255:0] i_wdata, d_wdata, i_rdata, d_rdata;
  logic         i_resp, d_resp;
  logic [31:0]  bmem_address;
  logic         bmem_read, bmem_write;
  logic [63:0]  bmem_wdata, bmem_rdata;
  logic         bmem_resp;

  bmem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_write(i_write), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .bmem_address(bmem_address), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_rdata(bmem_rdata), .bmem_resp(bmem_resp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stall_pct = 0;
  int tb_beat = 0;
  int last_beat_cyc = 0;
  int iresp_cnt = 0, dresp_cnt = 0, wr_cycles = 0;
  bit in_burst = 0, addr_changed = 0;
  logic [31:0]  cur_addr;
  logic [31:0]  addr_log[$];
  logic [63:0]  wbeat_log[$];
  bit           pattern[$];
  logic [255:0] mem [logic [31:0]];

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:5], 5'b0};
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock: step past the edge, then act as the burst memory for the
  // cycle that follows.
  task automatic tick();
    logic [255:0] ln;
    bit r;
    @(posedge clk);
    #1;
    cyc++;
    if (i_resp) iresp_cnt++;
    if (d_resp) dresp_cnt++;
    if (bmem_write) wr_cycles++;
    if (rst) begin
      bmem_resp = 1'b0;
      in_burst  = 0;
      tb_beat   = 0;
    end else if (bmem_read || bmem_write) begin
      if (!in_burst) begin
        in_burst = 1;
        cur_addr = bmem_address;
        addr_log.push_back(bmem_address);
        if (!mem.exists(cur_addr)) mem[cur_addr] = rand_line();
      end else if (bmem_address != cur_addr) begin
        addr_changed = 1;
      end
      if (pattern.size() > 0) r = pattern.pop_front();
      else r = ($urandom_range(0, 99) >= stall_pct);
      bmem_resp = r;
      ln = mem[cur_addr];
      if (r) begin
        if (bmem_read) begin
          bmem_rdata = ln[tb_beat*64 +: 64];
        end else begin
          ln[tb_beat*64 +: 64] = bmem_wdata;
          mem[cur_addr] = ln;
          wbeat_log.push_back(bmem_wdata);
        end
        if (tb_beat == 3) last_beat_cyc = cyc;
        tb_beat = (tb_beat + 1) % 4;
      end else begin
        bmem_rdata = {$urandom, $urandom};
      end
    end else begin
      // Outside a burst the handshake is meaningless; toggle it as noise.
      in_burst   = 0;
      tb_beat    = 0;
      bmem_resp  = 1'($urandom_range(0, 1));
      bmem_rdata = {$urandom, $urandom};
    end
  endtask

  task automatic wait_resp(input int budget, output int who, output int n,
                           output logic [255:0] il, output logic [255:0] dl);
    bit seen = 0;
    who = 0;
    n   = 0;
    il  = '0;
    dl  = '0;
    for (int k = 0; k < budget && !seen; k++) begin
      tick();
      n++;
      if (i_resp || d_resp) begin
        who  = (i_resp ? 1 : 0) + (d_resp ? 2 : 0);
        il   = i_rdata;
        dl   = d_rdata;
        seen = 1;
      end
    end
  endtask

  task automatic clear_logs();
    addr_log.delete();
    wbeat_log.delete();
    pattern.delete();
    iresp_cnt = 0;
    dresp_cnt = 0;
    wr_cycles = 0;
    addr_changed = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_read = 0; i_write = 0; d_read = 0; d_write = 0;
    bmem_resp = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_addr = 32'h0; d_addr = 32'h0; i_wdata = '0; d_wdata = '0;
    i_read = 1; i_write = 0; d_read = 0; d_write = 1;
    bmem_resp = 1'b1; bmem_rdata = '1;
    tick();
    tick();
    checks++;
    if ({bmem_read, bmem_write, i_resp, d_resp} !== 4'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 0000", {bmem_read, bmem_write, i_resp, d_resp});
    end
    checks++;
    if (bmem_address !== 32'h0 || bmem_wdata !== 64'h0) begin
      errors++;
      $display("FAIL reset_bmem_bus: addr %h wdata %h expected 0", bmem_address, bmem_wdata);
    end
    checks++;
    if (i_rdata !== '0 || d_rdata !== '0) begin
      errors++;
      $display("FAIL reset_rdata: i %h d %h expected 0", i_rdata, d_rdata);
    end
    do_reset();
  endtask

  task automatic test_icache_read();
    int who, n;
    logic [255:0] il, dl, exp_line;
    exp_line = 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111;
    mem[32'h0000_1220] = exp_line;
    stall_pct = 0;
    clear_logs();
    i_addr = 32'h0000_1234;
    i_read = 1;
    tick();
    checks++;
    if (bmem_read !== 1'b1 || bmem_write !== 1'b0 || bmem_address !== 32'h0000_1220) begin
      errors++;
      $display("FAIL icache_read_issue: read %b write %b addr %h expected 1 0 00001220",
               bmem_read, bmem_write, bmem_address);
    end
    wait_resp(20, who, n, il, dl);
    i_read = 0;
    checks++;
    if (who != 1 || n != 4) begin
      errors++;
      $display("FAIL icache_read_latency: who %0d at cycle %0d expected who 1 at cycle 5", who, n + 1);
    end
    checks++;
    if (il !== exp_line) begin
      errors++;
      $display("FAIL icache_read_data: got %h expected %h", il, exp_line);
    end
    tick();
    checks++;
    if (i_resp !== 1'b0 || iresp_cnt != 1 || dresp_cnt != 0) begin
      errors++;
      $display("FAIL icache_read_resp_pulse: i_resp %b icount %0d dcount %0d expected 0 1 0",
               i_resp, iresp_cnt, dresp_cnt);
    end
  endtask

  task automatic test_dcache_write();
    int who, n;
    logic [255:0] il, dl, line;
    logic [63:0] exp_beat [4];
    exp_beat[0] = 64'hAAAAAAAAAAAAAAAA;
    exp_beat[1] = 64'hBBBBBBBBBBBBBBBB;
    exp_beat[2] = 64'hCCCCCCCCCCCCCCCC;
    exp_beat[3] = 64'hDDDDDDDDDDDDDDDD;
    line = {exp_beat[3], exp_beat[2], exp_beat[1], exp_beat[0]};
    stall_pct = 0;
    clear_logs();
    d_addr = 32'h0000_8044;
    d_wdata = line;
    d_write = 1;
    wait_resp(20, who, n, il, dl);
    d_write = 0;
    checks++;
    if (who != 2 || n != 5 || wr_cycles != 4) begin
      errors++;
      $display("FAIL dcache_write_timing: who %0d resp cycle %0d write cycles %0d expected 2 5 4",
               who, n, wr_cycles);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wbeat_log.size() <= k || wbeat_log[k] !== exp_beat[k]) begin
        errors++;
        $display("FAIL dcache_write_beat%0d: got %h expected %h", k,
                 (wbeat_log.size() > k) ? wbeat_log[k] : 64'hx, exp_beat[k]);
      end
    end
    checks++;
    if (addr_log.size() != 1 || addr_log[0] !== 32'h0000_8040 || iresp_cnt != 0) begin
      errors++;
      $display("FAIL dcache_write_addr: bursts %0d addr %h icount %0d expected 1 00008040 0",
               addr_log.size(), (addr_log.size() > 0) ? addr_log[0] : 32'hx, iresp_cnt);
    end
  endtask

  task automatic test_tie_after_reset();
    int who1, who2, n;
    logic [255:0] il, dl;
    do_reset();
    stall_pct = 20;
    clear_logs();
    i_addr = 32'h0001_0000;
    d_addr = 32'h0002_0060;
    i_read = 1;
    d_read = 1;
    wait_resp(100, who1, n, il, dl);
    d_read = 0;
    wait_resp(100, who2, n, il, dl);
    i_read = 0;
    checks++;
    if (who1 != 2 || who2 != 1) begin
      errors++;
      $display("FAIL tie_order: got %0d then %0d expected 2 then 1", who1, who2);
    end
    checks++;
    if (addr_log.size() != 2 || addr_log[0] !== 32'h0002_0060 || addr_log[1] !== 32'h0001_0000) begin
      errors++;
      $display("FAIL tie_addr_order: count %0d expected 00020060 then 00010000", addr_log.size());
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int who, n, exp_who;
    logic [255:0] il, dl;
    stall_pct = 25;
    clear_logs();
    i_addr = 32'h0000_3000;
    d_addr = 32'h0000_4000;
    i_read = 1;
    d_read = 1;
    for (int k = 0; k < 4; k++) begin
      exp_who = (k % 2 == 0) ? 2 : 1;
      wait_resp(100, who, n, il, dl);
      checks++;
      if (who != exp_who) begin
        errors++;
        $display("FAIL alternate_%0d: got %0d expected %0d", k, who, exp_who);
      end
      if (who == 1) i_read = 0;
      if (who == 2) d_read = 0;
      tick();
      if (k < 3) begin
        i_read = 1;
        d_read = 1;
      end
    end
    i_read = 0;
    d_read = 0;
    tick();
  endtask

  task automatic test_stall_pattern();
    int who, n, t0;
    logic [255:0] il, dl;
    bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    clear_logs();
    for (int k = 0; k < 7; k++) pattern.push_back(pat[k]);
    i_addr = 32'h0000_5a5c;
    mem[32'h0000_5a40] = rand_line();
    i_read = 1;
    t0 = cyc;
    wait_resp(50, who, n, il, dl);
    i_read = 0;
    checks++;
    if (who != 1 || cyc - t0 != 8 || cyc != last_beat_cyc + 1) begin
      errors++;
      $display("FAIL stall_latency: who %0d resp cycle %0d last beat cycle %0d expected 1 8 %0d",
               who, cyc - t0, last_beat_cyc - t0, 7);
    end
    checks++;
    if (il !== mem[32'h0000_5a40]) begin
      errors++;
      $display("FAIL stall_data: got %h expected %h", il, mem[32'h0000_5a40]);
    end
    tick();
  endtask

  task automatic test_reset_midburst();
    int who, n;
    logic [255:0] il, dl;
    stall_pct = 0;
    clear_logs();
    d_addr = 32'h0000_9000;
    d_wdata = rand_line();
    d_write = 1;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (bmem_write !== 1'b0 || d_resp !== 1'b0) begin
      errors++;
      $display("FAIL midburst_reset_async: bmem_write %b d_resp %b expected 0 0", bmem_write, d_resp);
    end
    d_write = 0;
    tick();
    tick();
    rst = 1'b0;
    mem[32'h0000_a0e0] = rand_line();
    i_addr = 32'h0000_a0e8;
    i_read = 1;
    wait_resp(20, who, n, il, dl);
    i_read = 0;
    checks++;
    if (who != 1 || n != 5 || dresp_cnt != 0) begin
      errors++;
      $display("FAIL midburst_followup: who %0d cycle %0d dcount %0d expected 1 5 0", who, n, dresp_cnt);
    end
    checks++;
    if (il !== mem[32'h0000_a0e0]) begin
      errors++;
      $display("FAIL midburst_followup_data: got %h expected %h", il, mem[32'h0000_a0e0]);
    end
    tick();
  endtask

  task automatic test_random();
    int sel, first, exp_who, who, n, model_last;
    bit iw, dw;
    logic [31:0]  ia, da, ea;
    logic [255:0] iline, dline, il, dl, model_i, model_d;
    do_reset();
    model_i = '0;
    model_d = '0;
    model_last = 1;
    for (int it = 0; it < 16; it++) begin
      sel = $urandom_range(1, 3);
      stall_pct = $urandom_range(0, 50);
      ia = $urandom & 32'h7fff_ffff;
      da = $urandom | 32'h8000_0000;
      iw = 1'($urandom_range(0, 1));
      dw = 1'($urandom_range(0, 1));
      iline = rand_line();
      dline = rand_line();
      if (!mem.exists(align(ia))) mem[align(ia)] = rand_line();
      if (!mem.exists(align(da))) mem[align(da)] = rand_line();
      clear_logs();
      i_addr = ia; i_wdata = iline; i_write = sel[0] & iw; i_read = sel[0] & ~iw;
      d_addr = da; d_wdata = dline; d_write = sel[1] & dw; d_read = sel[1] & ~dw;
      first = (sel == 3) ? ((model_last == 1) ? 2 : 1) : sel;
      for (int t = 0; t < ((sel == 3) ? 2 : 1); t++) begin
        exp_who = (t == 0) ? first : 3 - first;
        if (t == 0) begin
          tick();
          tick();
          // The owner has been granted; later edits must not leak in.
          if (exp_who == 1) begin i_addr = ia ^ 32'h0000_0fe0; i_wdata = ~iline; end
          else              begin d_addr = da ^ 32'h0000_0fe0; d_wdata = ~dline; end
        end
        wait_resp(300, who, n, il, dl);
        checks++;
        if (who != exp_who) begin
          errors++;
          $display("FAIL random_%0d_owner: got %0d expected %0d", it, who, exp_who);
        end
        ea = (exp_who == 1) ? align(ia) : align(da);
        checks++;
        if (exp_who == 1 && !iw && il !== mem[ea]) begin
          errors++;
          $display("FAIL random_%0d_iread: got %h expected %h", it, il, mem[ea]);
        end else if (exp_who == 1 && iw && mem[ea] !== iline) begin
          errors++;
          $display("FAIL random_%0d_iwrite: got %h expected %h", it, mem[ea], iline);
        end else if (exp_who == 2 && !dw && dl !== mem[ea]) begin
          errors++;
          $display("FAIL random_%0d_dread: got %h expected %h", it, dl, mem[ea]);
        end else if (exp_who == 2 && dw && mem[ea] !== dline) begin
          errors++;
          $display("FAIL random_%0d_dwrite: got %h expected %h", it, mem[ea], dline);
        end
        if (exp_who == 1 && !iw) model_i = mem[ea];
        if (exp_who == 2 && !dw) model_d = mem[ea];
        checks++;
        if ((exp_who == 1 && dl !== model_d) || (exp_who == 2 && il !== model_i)) begin
          errors++;
          $display("FAIL random_%0d_rdata_hold: i %h d %h", it, il, dl);
        end
        checks++;
        if (addr_log.size() == 0 || addr_log.pop_front() !== ea) begin
          errors++;
          $display("FAIL random_%0d_address: expected %h", it, ea);
        end
        if (exp_who == 1) begin i_read = 0; i_write = 0; end
        else              begin d_read = 0; d_write = 0; end
        model_last = exp_who;
      end
      tick();
      checks++;
      if (addr_changed) begin
        errors++;
        $display("FAIL random_%0d_addr_stable: address moved during a burst", it);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    i_read = 0; i_write = 0; d_read = 0; d_write = 0;
    i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0;
    bmem_resp = 1'b0; bmem_rdata = '0;
    test_reset();
    test_icache_read();
    test_dcache_write();
    test_tie_after_reset();
    test_back_to_back();
    test_stall_pattern();
    test_reset_midburst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
